// File: rtl/s641_bist_pkg.sv
// Shared types and constants for the s641 BIST driver/observer.
package s641_bist_pkg;

    localparam int unsigned PI_W_DEF = 35;
    localparam int unsigned PO_W_DEF = 24;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned WCNT_W   = 8;

    localparam int unsigned LFSR_TAP_HI = 34;
    localparam int unsigned LFSR_TAP_LO = 1;

    localparam int unsigned MISR_TAP_A = 23;
    localparam int unsigned MISR_TAP_B = 22;
    localparam int unsigned MISR_TAP_C = 21;
    localparam int unsigned MISR_TAP_D = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    // Fibonacci LFSR step, x^35 + x^2 + 1
    function automatic logic [PI_W_DEF-1:0] lfsr_step(input logic [PI_W_DEF-1:0] q);
        return {q[PI_W_DEF-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};
    endfunction

    // One MISR compaction step, x^24 + x^23 + x^22 + x^17 + 1
    function automatic logic [PO_W_DEF-1:0] misr_step(input logic [PO_W_DEF-1:0] m,
                                                      input logic [PO_W_DEF-1:0] d);
        return {m[PO_W_DEF-2:0],
                m[MISR_TAP_A] ^ m[MISR_TAP_B] ^ m[MISR_TAP_C] ^ m[MISR_TAP_D]} ^ d;
    endfunction

endpackage

// File: rtl/s641_misr.sv
// Multiple-input signature register; clear has priority over enable.
module s641_misr
    import s641_bist_pkg::*;
#(
    parameter int unsigned PO_W  = PO_W_DEF,
    parameter int unsigned TAP_A = MISR_TAP_A,
    parameter int unsigned TAP_B = MISR_TAP_B,
    parameter int unsigned TAP_C = MISR_TAP_C,
    parameter int unsigned TAP_D = MISR_TAP_D
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [PO_W-1:0] data,
    output logic [PO_W-1:0] sig
);

    logic [PO_W-1:0] r_sig;
    logic            w_fb;

    assign w_fb = r_sig[TAP_A] ^ r_sig[TAP_B] ^ r_sig[TAP_C] ^ r_sig[TAP_D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (clear) begin
            r_sig <= '0;
        end else if (enable) begin
            r_sig <= {r_sig[PO_W-2:0], w_fb} ^ data;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/s641_bist_ctrl.sv
// BIST controller for s641: LFSR pattern source, MISR response compactor,
// golden-signature check.
module s641_bist_ctrl
    import s641_bist_pkg::*;
#(
    parameter int unsigned     PI_W       = PI_W_DEF,
    parameter int unsigned     PO_W       = PO_W_DEF,
    parameter int unsigned     WARM_CYC   = 8,
    parameter int unsigned     PAT_CNT    = 1024,
    parameter logic [PI_W-1:0] SEED       = PI_W'(1),
    parameter logic [PO_W-1:0] GOLDEN_SIG = '0
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             ABORT,
    output logic [PI_W-1:0]  PI_OUT,
    input  logic [PO_W-1:0]  PO_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [PO_W-1:0]  SIG,
    output logic [CNT_W-1:0] PAT_IDX
);

    localparam logic [PI_W-1:0]   SEED_EFF  = (SEED == '0) ? PI_W'(1) : SEED;
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARM_CYC - 1);
    localparam logic [CNT_W-1:0]  PAT_LAST  = CNT_W'(PAT_CNT - 1);

    bist_state_e       r_state, w_state_nxt;
    logic [PI_W-1:0]   r_lfsr,  w_lfsr_nxt;
    logic [PI_W-1:0]   r_pi,    w_pi_nxt;
    logic [WCNT_W-1:0] r_wcnt,  w_wcnt_nxt;
    logic [CNT_W-1:0]  r_pat,   w_pat_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic              r_pass,  w_pass_nxt;
    logic              w_misr_clr;
    logic              w_misr_en;
    logic [PO_W-1:0]   w_sig;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_lfsr  <= SEED_EFF;
            r_pi    <= '0;
            r_wcnt  <= '0;
            r_pat   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_pi    <= w_pi_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_pat   <= w_pat_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // PI_OUT always carries the pattern the LFSR produced one step earlier,
    // so the MISR sees the s641 response to the pattern currently on the pins.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_pi_nxt    = r_pi;
        w_wcnt_nxt  = r_wcnt;
        w_pat_nxt   = r_pat;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_misr_clr  = 1'b0;
        w_misr_en   = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    w_state_nxt = ST_WARM;
                    w_pi_nxt    = SEED_EFF;
                    w_lfsr_nxt  = lfsr_step(SEED_EFF);
                    w_wcnt_nxt  = '0;
                    w_pat_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_misr_clr  = 1'b1;
                end
            end
            ST_WARM, ST_RUN: begin
                if (ABORT) begin
                    w_state_nxt = ST_IDLE;
                    w_pi_nxt    = '0;
                    w_wcnt_nxt  = '0;
                    w_pat_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_misr_clr  = 1'b1;
                end else begin
                    w_pi_nxt   = r_lfsr;
                    w_lfsr_nxt = lfsr_step(r_lfsr);
                    if (r_state == ST_WARM) begin
                        if (r_wcnt == WARM_LAST) begin
                            w_state_nxt = ST_RUN;
                            w_wcnt_nxt  = '0;
                        end else begin
                            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                        end
                    end else begin
                        w_misr_en = 1'b1;
                        w_pat_nxt = r_pat + CNT_W'(1);
                        if (r_pat == PAT_LAST) begin
                            // Final compaction: judge the signature it will produce.
                            w_state_nxt = ST_DONE;
                            w_pi_nxt    = '0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_pass_nxt  = (misr_step(w_sig, PO_IN) == GOLDEN_SIG);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    s641_misr #(
        .PO_W (PO_W)
    ) u_misr (
        .clk    (CK),
        .rst_n  (RSTN),
        .clear  (w_misr_clr),
        .enable (w_misr_en),
        .data   (PO_IN),
        .sig    (w_sig)
    );

    assign PI_OUT  = r_pi;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign PASS    = r_pass;
    assign SIG     = w_sig;
    assign PAT_IDX = r_pat;

endmodule

// File: doc/s641_bist_ctrl.md
Name: s641_bist_ctrl

Overview:
- Built-in self-test driver and observer for the s641 sequential core. It is the other end of the s641 pin interface.
- Drives all 35 s641 primary inputs from a pseudo-random pattern generator (LFSR).
- Compacts the 24 s641 primary outputs into a multiple-input signature register (MISR).
- Compares the final signature against a golden value and reports PASS/DONE. Sits beside the s641 instance in the test wrapper.

Parameters:
- PI_W, 35, width of pattern bus (s641 inputs).
- PO_W, 24, width of response bus (s641 outputs).
- WARM_CYC, 8, cycles applied before compaction starts. Flushes the 19 un-reset s641 flops; range 1..255.
- PAT_CNT, 1024, compacted patterns per run; range 1..65535.
- SEED, 35'h1, LFSR start value. A zero value is replaced by 35'h1.
- GOLDEN_SIG, 24'h0, expected final signature.

Ports:
- CK, input, 1, clock (rising edge).
- RSTN, input, 1, asynchronous active-low reset.
- START, input, 1, single-cycle request to begin a run.
- ABORT, input, 1, terminate the current run.
- PI_OUT, output, 35, pattern to s641 inputs G1..G36 (bit order fixed by wrapper).
- PO_IN, input, 24, s641 outputs, sampled each active cycle.
- BUSY, output, 1, high in WARM and RUN.
- DONE, output, 1, high in DONE state.
- PASS, output, 1, valid when DONE=1: SIG==GOLDEN_SIG.
- SIG, output, 24, current MISR contents.
- PAT_IDX, output, 16, compacted patterns so far in this run.

Behaviour:
- Clock and reset: one clock, CK. Reset RSTN is asynchronous, active-low.
- Reset values: state=IDLE; LFSR=SEED; MISR=0; counters=0; PI_OUT=0, BUSY=0, DONE=0, PASS=0, SIG=0, PAT_IDX=0. Reset asserted mid-run aborts immediately with the same values.
- States: IDLE, WARM, RUN, DONE.
- IDLE:
  - PI_OUT=0.
  - START=1 -> WARM next edge; LFSR reloads SEED, MISR=0, counters=0.
- WARM:
  - PI_OUT=LFSR; LFSR advances every cycle; MISR holds.
  - After WARM_CYC cycles -> RUN.
- RUN:
  - PI_OUT=LFSR; LFSR advances every cycle.
  - MISR compacts PO_IN each cycle; PO_IN is sampled the same cycle PI_OUT is presented (s641 outputs are combinational from inputs plus state).
  - PAT_IDX increments per compaction.
  - When PAT_IDX reaches PAT_CNT -> DONE.
- DONE:
  - PI_OUT=0; PASS registered as (MISR==GOLDEN_SIG); SIG held.
  - START -> WARM (full re-init, DONE/PASS cleared). Otherwise hold.
- LFSR (Fibonacci): fb = q[34]^q[1]; q_next = {q[33:0], fb}. Polynomial x^35+x^2+1, period 2^35-1; never zero.
- MISR: fb = m[23]^m[22]^m[21]^m[16]; m_next = {m[22:0], fb} ^ PO_IN. Polynomial x^24+x^23+x^22+x^17+1.
- ABORT in WARM or RUN -> IDLE next edge; MISR=0, PAT_IDX=0, PASS=0. ABORT in IDLE or DONE is ignored.
- START while BUSY is ignored.
- START and ABORT together in WARM/RUN: ABORT wins. In IDLE/DONE: START wins.
- Latency: first pattern appears one cycle after START. DONE asserts WARM_CYC+PAT_CNT+1 cycles after the START cycle.
- No combinational path from PO_IN to any output; all outputs are registered.

Decomposition:
- Package s641_bist_pkg holds:
  - PI_W/PO_W defaults;
  - LFSR tap constants (34,1) and MISR tap constants (23,22,21,16);
  - the state enum {IDLE, WARM, RUN, DONE}.
- One sub-module, s641_misr: PO_W-wide, with inputs clear, enable, data and output sig. It is reusable for other ISCAS wrappers.
- LFSR, counters and FSM stay inline in s641_bist_ctrl.

Test Plan:
- Reset mid-RUN (RSTN low for 1 cycle at PAT_IDX=5) -> all outputs 0 and BUSY=0 immediately, asynchronously.
- SEED=1, START pulse -> BUSY=1 next cycle; PI_OUT sequence 35'h1, 35'h2, 35'h4, ... with no MISR change for 8 cycles; after 35 shifts the LFSR feedback wraps correctly (compare against the reference model).
- PAT_CNT=2, WARM_CYC=1, PO_IN held 24'h000001 -> SIG=24'h000003, PAT_IDX=2, DONE=1; PASS=0 with GOLDEN_SIG=0, PASS=1 with GOLDEN_SIG=24'h3.
- PO_IN held 0, GOLDEN_SIG=0, PAT_CNT=1024 -> DONE exactly 1033 cycles after the START cycle, SIG=0, PASS=1.
- ABORT at PAT_IDX=10 -> IDLE next cycle, PI_OUT=0, SIG=0, DONE=0. A simultaneous START in the same cycle is ignored.
- START asserted during RUN ignored (PAT_IDX keeps counting). START in DONE restarts: DONE=0 next cycle and PI_OUT=SEED.
